comnet_master: RTL
==================

// Module: comnet_master
// PURPOSE
//  Host-side serial command master for the comnet register link. Takes one
//  parallel command (8-bit register offset, R/W, 32-bit write data), generates
//  start/stop framing on SDa/SCl, serialises it, and captures 32 read-back
//  bits from RDa. Sits directly upstream of comnet (slave decode, 0x9000 page).
// PARAMETERS
//  CLK_DIV      4   clk cycles per SCl half-period; legal range 3..255
//  FRAME_BITS   48  SCl bit periods per frame; must be >= RD_FIRST_BIT+32
//  RD_FIRST_BIT 16  bit index, 1-based, of the first RDa data bit (MSB)
// PORTS
//  clk        in   1   system clock; all logic on its rising edge
//  rst        in   1   synchronous, active-high reset
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   master idle; command accepted when valid&&ready
//  cmd_rd     in   1   1 = read, 0 = write
//  cmd_addr   in   8   register offset (slave supplies upper byte 0x90)
//  cmd_wdata  in   32  write data (ignored for reads)
//  resp_valid out  1   one-clk pulse at end of frame
//  resp_rdata out  32  captured read data; valid with resp_valid, held after
//  SDa        out  1   serial data line to slave
//  SCl        out  1   serial clock line to slave
//  RDa        in   1   serial return data from slave
//  frame_cnt  out  16  completed frames (only with COMNET_M_STATS_EN)
// BEHAVIOUR
//  Reset: SCl=1, SDa=1, cmd_ready=1, resp_valid=0, resp_rdata=0,
//   state=IDLE, frame_cnt=0. A reset mid-frame aborts immediately; the bus
//   returns to idle the next clk and no resp_valid is issued.
//  Accept: on the edge with cmd_valid&&cmd_ready, latch the 41-bit shift word
//   {cmd_addr[7:0], cmd_rd, cmd_wdata[31:0]}, MSB first; bits 42..FRAME_BITS
//   are sent as 0. cmd_ready drops on the next clk and stays low to DONE.
//  FSM: IDLE -> START -> SHIFT -> STOP -> GAP -> DONE -> IDLE.
//   START: SDa=0, SCl=1 for CLK_DIV clks (start condition).
//   SHIFT: for bit k = 1..FRAME_BITS: low half (SCl=0, SDa=bit k, set on
//    the first clk of the half) for CLK_DIV clks, then high half (SCl=1)
//    for CLK_DIV clks. SDa never changes while SCl=1 in SHIFT.
//    Write frame: slave samples addr/RW at k=1..9 and data at k=10..41.
//   STOP: SCl=0, SDa=0 for CLK_DIV clks; SCl=1, SDa=0 for CLK_DIV clks.
//   GAP: SDa=1, SCl=1 (stop condition) for CLK_DIV clks.
//   DONE: resp_valid=1 for one clk, cmd_ready=1 next clk.
//  Latency: resp_valid is exactly 100*CLK_DIV clks after the accepting edge
//   at defaults (CLK_DIV*(2*FRAME_BITS+4) in general).
//  Read capture: RDa passes through a 2-flop synchroniser. On the last clk
//   of the high half of bit k, for RD_FIRST_BIT <= k < RD_FIRST_BIT+32,
//   shift the synced RDa into resp_rdata, MSB first. Capture also runs on
//   writes; resp_rdata is then don't-care but deterministic.
//  The phase counter is 8 bits, the bit counter 6 bits; no wrap occurs
//   inside a legal frame.
//  cmd_valid while busy: ignored, no queueing; the command must be held.
//  Back-to-back commands: the next START begins no earlier than 1 clk
//   after DONE, so GAP guarantees >= CLK_DIV clks of idle bus.
// CONFIGURATION
//  COMNET_M_STATS_EN defined: frame_cnt port exists; increments by 1 in DONE,
//   wraps 0xFFFF->0, cleared by rst, not incremented by aborted frames.
//  COMNET_M_STATS_EN undefined: no frame_cnt port, no counter logic.
// TESTING
//  Write addr=0x12, data=0xDEADBEEF -> SDa bits 1..41 = 0x12,0,0xDEADBEEF;
//   resp_valid at accept+400 clks; comnet model issues wr with addr 0x9012.
//  Read addr=0x34, slave model returns 0xA5A5_0F0F -> resp_rdata=0xA5A50F0F.
//  Framing check: SDa toggles with SCl=1 only at start (1->0) and at
//   GAP (0->1), nowhere else in the frame.
//  Assert rst at bit 20 of a read -> SCl=SDa=1 next clk, no resp_valid;
//   the following write completes normally.
//  cmd_valid held through two commands -> second START is >= 4 clks after
//   the first stop; cmd_ready low for the whole frame; with
//   COMNET_M_STATS_EN, frame_cnt=2.

Source files
------------

// File: rtl/comnet_master.sv
// comnet_master: serial command master for the comnet register link.
// Optional frame counter enabled by defining COMNET_M_STATS_EN.
module comnet_master #(
  parameter int CLK_DIV      = 4,
  parameter int FRAME_BITS   = 48,
  parameter int RD_FIRST_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rd,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        SDa,
  output logic        SCl,
  input  logic        RDa
`ifdef COMNET_M_STATS_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam logic [7:0] PH_LAST = 8'(CLK_DIV - 1);
  localparam logic [5:0] BIT_LAST = 6'(FRAME_BITS);
  localparam logic [6:0] RD_LO = 7'(RD_FIRST_BIT);
  localparam logic [6:0] RD_HI = 7'(RD_FIRST_BIT + 32);

  logic [2:0]  state;
  logic [7:0]  phase;
  logic        half;
  logic [5:0]  bitcnt;
  logic [40:0] sh;
  logic        rda_s1;
  logic        rda_s2;
  logic        ph_end;
  logic        cap_en;

  assign ph_end = (phase == PH_LAST);
  assign cmd_ready = (state == IDLE);
  assign cap_en = (state == SHIFT) && half && ph_end
               && ({1'b0, bitcnt} >= RD_LO)
               && ({1'b0, bitcnt} < RD_HI);

  // two-flop synchroniser for the return data line
  always_ff @(posedge clk) begin
    if (rst) begin
      rda_s1 <= 1'b1;
      rda_s2 <= 1'b1;
    end else begin
      rda_s1 <= RDa;
      rda_s2 <= rda_s1;
    end
  end

  // frame sequencer: state, half-period timing and the shift word
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= '0;
      half       <= 1'b0;
      bitcnt     <= '0;
      sh         <= '0;
      resp_valid <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            sh    <= {cmd_addr, cmd_rd, cmd_wdata};
            state <= START;
            phase <= '0;
            half  <= 1'b0;
          end
        end
        START: begin
          if (ph_end) begin
            phase  <= '0;
            half   <= 1'b0;
            bitcnt <= 6'd1;
            state  <= SHIFT;
          end else begin
            phase <= phase + 8'd1;
          end
        end
        SHIFT: begin
          if (ph_end) begin
            phase <= '0;
            half  <= ~half;
            if (half) begin
              sh <= {sh[39:0], 1'b0};
              if (bitcnt == BIT_LAST) begin
                state <= STOP;
                half  <= 1'b0;
              end else begin
                bitcnt <= bitcnt + 6'd1;
              end
            end
          end else begin
            phase <= phase + 8'd1;
          end
        end
        STOP: begin
          if (ph_end) begin
            phase <= '0;
            half  <= ~half;
            if (half) begin
              state <= GAP;
              half  <= 1'b0;
            end
          end else begin
            phase <= phase + 8'd1;
          end
        end
        GAP: begin
          if (ph_end) begin
            phase      <= '0;
            state      <= DONE;
            resp_valid <= 1'b1;
          end else begin
            phase <= phase + 8'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // read-back capture, MSB first, on the last clk of each high half
  always_ff @(posedge clk) begin
    if (rst) resp_rdata <= '0;
    else if (cap_en) resp_rdata <= {resp_rdata[30:0], rda_s2};
  end

  // bus line levels decoded from the sequencer state
  always_comb begin
    SCl = 1'b1;
    SDa = 1'b1;
    case (state)
      START: begin
        SCl = 1'b1;
        SDa = 1'b0;
      end
      SHIFT: begin
        SCl = half;
        SDa = sh[40];
      end
      STOP: begin
        SCl = half;
        SDa = 1'b0;
      end
      default: begin
        SCl = 1'b1;
        SDa = 1'b1;
      end
    endcase
  end

`ifdef COMNET_M_STATS_EN
  // completed-frame counter, wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (rst) frame_cnt <= '0;
    else if (state == DONE) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule
